// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among C_RPORT read requesters and one
// write requester; accesses are serialised and guarded by a per-access watchdog.
module mem_arbiter #(
    parameter int C_RPORT = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [C_RPORT-1:0]        c_re,
    input  logic [C_RPORT*ADDR_W-1:0] c_raddr,
    input  logic [C_RPORT*2-1:0]      c_rlen,
    output logic [C_RPORT*DATA_W-1:0] c_dout,
    output logic [C_RPORT-1:0]        c_rack,
    input  logic                      c_we,
    input  logic [ADDR_W-1:0]         c_waddr,
    input  logic [1:0]                c_wlen,
    input  logic [DATA_W-1:0]         c_din,
    output logic                      c_wack,
    output logic                      m_re,
    output logic                      m_we,
    output logic [ADDR_W-1:0]         m_raddr,
    output logic [ADDR_W-1:0]         m_waddr,
    output logic [1:0]                m_rlen,
    output logic [1:0]                m_wlen,
    output logic [DATA_W-1:0]         m_dout,
    input  logic [DATA_W-1:0]         m_din,
    input  logic                      m_rack,
    input  logic                      m_wack,
    output logic                      busy,
    output logic                      err,
    output logic [2:0]                err_port
);

    localparam int NREQ  = C_RPORT + 1;
    localparam int IDX_W = 3;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] WR_IDX  = IDX_W'(C_RPORT);
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                    state_r, state_s;
    logic [IDX_W-1:0]          rr_last_r, rr_last_s;
    logic [IDX_W-1:0]          win_r, win_s;
    logic [CNT_W-1:0]          cnt_r, cnt_s, cnt_inc_s;
    logic                      m_re_r, m_re_s;
    logic                      m_we_r, m_we_s;
    logic [ADDR_W-1:0]         m_raddr_r, m_raddr_s;
    logic [ADDR_W-1:0]         m_waddr_r, m_waddr_s;
    logic [1:0]                m_rlen_r, m_rlen_s;
    logic [1:0]                m_wlen_r, m_wlen_s;
    logic [DATA_W-1:0]         m_dout_r, m_dout_s;
    logic [C_RPORT*DATA_W-1:0] dout_r, dout_s;
    logic [C_RPORT-1:0]        rack_r, rack_s;
    logic                      wack_r, wack_s;
    logic                      busy_r, busy_s;
    logic                      err_r, err_s;
    logic [IDX_W-1:0]          err_port_r, err_port_s;

    logic [NREQ-1:0]           req_s;
    logic                      found_s;
    logic [IDX_W-1:0]          grant_s;
    int                        best_s;
    int                        dist_s;
    logic                      take_s;
    logic [ADDR_W-1:0]         sel_raddr_s;
    logic [1:0]                sel_rlen_s;
    logic                      win_is_write_s;
    logic                      mem_ack_s;
    logic                      wd_expire_s;

    function automatic logic [C_RPORT*DATA_W-1:0] put_slice(
        input logic [C_RPORT*DATA_W-1:0] vec,
        input logic [IDX_W-1:0]          idx,
        input logic [DATA_W-1:0]         val
    );
        logic [C_RPORT*DATA_W-1:0] res;
        res = vec;
        for (int p = 0; p < C_RPORT; p++) begin
            res[p*DATA_W +: DATA_W] = (idx == IDX_W'(p)) ? val : vec[p*DATA_W +: DATA_W];
        end
        return res;
    endfunction

    function automatic logic [C_RPORT-1:0] port_onehot(input logic [IDX_W-1:0] idx);
        logic [C_RPORT-1:0] res;
        res = '0;
        for (int p = 0; p < C_RPORT; p++) begin
            res[p] = (idx == IDX_W'(p));
        end
        return res;
    endfunction

    assign req_s          = {c_we, c_re};
    assign win_is_write_s = (win_r == WR_IDX);
    assign mem_ack_s      = win_is_write_s ? m_wack : m_rack;
    assign cnt_inc_s      = cnt_r + CNT_W'(1);
    assign wd_expire_s    = (TIMEOUT != 0) && (cnt_inc_s == TMO_CNT);

    // Round-robin pick: distance 0 is the requester right after the last winner
    always_comb begin
        best_s      = NREQ;
        dist_s      = 0;
        take_s      = 1'b0;
        grant_s     = '0;
        sel_raddr_s = '0;
        sel_rlen_s  = 2'b00;
        found_s     = |req_s;
        for (int c = 0; c < NREQ; c++) begin
            dist_s  = (c + NREQ - 1 - int'(rr_last_r)) % NREQ;
            take_s  = req_s[c] && (dist_s < best_s);
            best_s  = take_s ? dist_s : best_s;
            grant_s = take_s ? IDX_W'(c) : grant_s;
        end
        for (int p = 0; p < C_RPORT; p++) begin
            sel_raddr_s = (grant_s == IDX_W'(p)) ? c_raddr[p*ADDR_W +: ADDR_W] : sel_raddr_s;
            sel_rlen_s  = (grant_s == IDX_W'(p)) ? c_rlen[p*2 +: 2] : sel_rlen_s;
        end
    end

    // Next-state and next-output logic for the access sequencer
    always_comb begin
        state_s    = state_r;
        rr_last_s  = rr_last_r;
        win_s      = win_r;
        cnt_s      = cnt_r;
        m_re_s     = m_re_r;
        m_we_s     = m_we_r;
        m_raddr_s  = m_raddr_r;
        m_waddr_s  = m_waddr_r;
        m_rlen_s   = m_rlen_r;
        m_wlen_s   = m_wlen_r;
        m_dout_s   = m_dout_r;
        dout_s     = dout_r;
        rack_s     = '0;
        wack_s     = 1'b0;
        err_s      = 1'b0;
        err_port_s = err_port_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_s   = ST_ISSUE;
                    win_s     = grant_s;
                    rr_last_s = grant_s;
                    if (grant_s == WR_IDX) begin
                        m_we_s    = 1'b1;
                        m_waddr_s = c_waddr;
                        m_wlen_s  = c_wlen;
                        m_dout_s  = c_din;
                    end else begin
                        m_re_s    = 1'b1;
                        m_raddr_s = sel_raddr_s;
                        m_rlen_s  = sel_rlen_s;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_s   = '0;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_s = cnt_inc_s;
                // A matching ack on the expiry cycle still wins over the watchdog
                if (mem_ack_s) begin
                    state_s = ST_RESP;
                    m_re_s  = 1'b0;
                    m_we_s  = 1'b0;
                    dout_s  = put_slice(dout_r, win_r, m_din);
                    rack_s  = port_onehot(win_r);
                    wack_s  = win_is_write_s;
                end else if (wd_expire_s) begin
                    state_s    = ST_RESP;
                    m_re_s     = 1'b0;
                    m_we_s     = 1'b0;
                    dout_s     = put_slice(dout_r, win_r, {DATA_W{1'b0}});
                    rack_s     = port_onehot(win_r);
                    wack_s     = win_is_write_s;
                    err_s      = 1'b1;
                    err_port_s = win_r;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rr_last_r  <= WR_IDX;
            win_r      <= '0;
            cnt_r      <= '0;
            m_re_r     <= 1'b0;
            m_we_r     <= 1'b0;
            m_raddr_r  <= '0;
            m_waddr_r  <= '0;
            m_rlen_r   <= 2'b00;
            m_wlen_r   <= 2'b00;
            m_dout_r   <= '0;
            dout_r     <= '0;
            rack_r     <= '0;
            wack_r     <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            err_port_r <= '0;
        end else begin
            state_r    <= state_s;
            rr_last_r  <= rr_last_s;
            win_r      <= win_s;
            cnt_r      <= cnt_s;
            m_re_r     <= m_re_s;
            m_we_r     <= m_we_s;
            m_raddr_r  <= m_raddr_s;
            m_waddr_r  <= m_waddr_s;
            m_rlen_r   <= m_rlen_s;
            m_wlen_r   <= m_wlen_s;
            m_dout_r   <= m_dout_s;
            dout_r     <= dout_s;
            rack_r     <= rack_s;
            wack_r     <= wack_s;
            busy_r     <= busy_s;
            err_r      <= err_s;
            err_port_r <= err_port_s;
        end
    end

    assign c_dout   = dout_r;
    assign c_rack   = rack_r;
    assign c_wack   = wack_r;
    assign m_re     = m_re_r;
    assign m_we     = m_we_r;
    assign m_raddr  = m_raddr_r;
    assign m_waddr  = m_waddr_r;
    assign m_rlen   = m_rlen_r;
    assign m_wlen   = m_wlen_r;
    assign m_dout   = m_dout_r;
    assign busy     = busy_r;
    assign err      = err_r;
    assign err_port = err_port_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level round-robin model, randomized
// memory latencies (including watchdog expiry) and a decoupled output monitor.
module tb_mem_arbiter;
    localparam int C_RPORT = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 4;
    localparam int NREQ    = C_RPORT + 1;

    logic                      clk;
    logic                      rst;
    logic [C_RPORT-1:0]        c_re;
    logic [C_RPORT*ADDR_W-1:0] c_raddr;
    logic [C_RPORT*2-1:0]      c_rlen;
    logic [C_RPORT*DATA_W-1:0] c_dout;
    logic [C_RPORT-1:0]        c_rack;
    logic                      c_we;
    logic [ADDR_W-1:0]         c_waddr;
    logic [1:0]                c_wlen;
    logic [DATA_W-1:0]         c_din;
    logic                      c_wack;
    logic                      m_re, m_we;
    logic [ADDR_W-1:0]         m_raddr, m_waddr;
    logic [1:0]                m_rlen, m_wlen;
    logic [DATA_W-1:0]         m_dout;
    logic [DATA_W-1:0]         m_din;
    logic                      m_rack, m_wack;
    logic                      busy, err;
    logic [2:0]                err_port;

    mem_arbiter #(.C_RPORT(C_RPORT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .c_re(c_re), .c_raddr(c_raddr), .c_rlen(c_rlen),
        .c_dout(c_dout), .c_rack(c_rack), .c_we(c_we), .c_waddr(c_waddr), .c_wlen(c_wlen),
        .c_din(c_din), .c_wack(c_wack), .m_re(m_re), .m_we(m_we), .m_raddr(m_raddr),
        .m_waddr(m_waddr), .m_rlen(m_rlen), .m_wlen(m_wlen), .m_dout(m_dout), .m_din(m_din),
        .m_rack(m_rack), .m_wack(m_wack), .busy(busy), .err(err), .err_port(err_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [63:0] wdata;
        int          lat;
        logic [63:0] rdata;
    } acc_t;

    acc_t exp_q[$];
    acc_t mem_q[$];
    logic [63:0] model_dout [C_RPORT];
    bit          abort_cur = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          rr_m;

    logic [31:0] rq_addr  [NREQ];
    logic [1:0]  rq_len   [NREQ];
    logic [63:0] rq_data  [NREQ];
    logic [63:0] rq_rdata [NREQ];
    int          rq_lat   [NREQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dout0"}, c_dout[63:0], 64'd0);
        check({tag, "_dout1"}, c_dout[127:64], 64'd0);
        check({tag, "_acks"}, {61'd0, c_rack, c_wack}, 64'd0);
        check({tag, "_mem_en"}, {62'd0, m_re, m_we}, 64'd0);
        check({tag, "_maddr"}, {m_raddr, m_waddr}, 64'd0);
        check({tag, "_mlen"}, {60'd0, m_rlen, m_wlen}, 64'd0);
        check({tag, "_mdout"}, m_dout, 64'd0);
        check({tag, "_busy_err"}, {59'd0, busy, err, err_port}, 64'd0);
    endtask

    // Memory responder: ack in WAIT cycle 'lat' after issue, noise acks of the wrong type
    initial begin
        int   mcnt;
        bit   prev;
        bit   wr;
        acc_t a;
        logic [63:0] rd;
        mcnt = 0; prev = 1'b0; wr = 1'b0; rd = '0;
        m_rack = 1'b0; m_wack = 1'b0; m_din = '0;
        forever begin
            @(negedge clk);
            m_rack = 1'b0; m_wack = 1'b0; m_din = {$urandom, $urandom};
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    if (wr) m_wack = 1'b1;
                    else begin m_rack = 1'b1; m_din = rd; end
                end else if ($urandom_range(0, 3) == 0) begin
                    if (wr) m_rack = 1'b1;
                    else m_wack = 1'b1;
                end
            end
            if ((m_re || m_we) && !prev && mem_q.size() != 0) begin
                a = mem_q.pop_front();
                mcnt = a.lat; wr = m_we; rd = a.rdata;
            end
            prev = m_re || m_we;
        end
    end

    // Monitor: compares each issue and each completion against the scoreboard
    initial begin
        acc_t cur;
        bit   cur_valid;
        bit   prev;
        bit   tmo;
        bit   is_wr;
        int   issue_cyc;
        logic [C_RPORT-1:0] exp_rack;
        cur_valid = 1'b0; prev = 1'b0; issue_cyc = 0;
        for (int p = 0; p < C_RPORT; p++) model_dout[p] = '0;
        forever begin
            @(negedge clk);
            if (abort_cur) begin
                cur_valid = 1'b0; abort_cur = 1'b0;
                for (int p = 0; p < C_RPORT; p++) model_dout[p] = '0;
            end
            if ((m_re || m_we) && !prev) begin
                if (exp_q.size() == 0 || cur_valid) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue: got m_re=%0b m_we=%0b required no issue (cycle %0d)", m_re, m_we, cyc);
                end else begin
                    cur = exp_q.pop_front(); cur_valid = 1'b1; issue_cyc = cyc;
                    is_wr = (cur.idx == C_RPORT);
                    check("issue_we", {63'd0, m_we}, {63'd0, is_wr});
                    check("issue_re", {63'd0, m_re}, {63'd0, !is_wr});
                    if (is_wr) begin
                        check("issue_waddr", {32'd0, m_waddr}, {32'd0, cur.addr});
                        check("issue_wlen", {62'd0, m_wlen}, {62'd0, cur.len});
                        check("issue_wdata", m_dout, cur.wdata);
                    end else begin
                        check("issue_raddr", {32'd0, m_raddr}, {32'd0, cur.addr});
                        check("issue_rlen", {62'd0, m_rlen}, {62'd0, cur.len});
                    end
                end
            end
            prev = m_re || m_we;
            if ((|c_rack) || c_wack) begin
                if (!cur_valid) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: got rack=%b wack=%b required none (cycle %0d)", c_rack, c_wack, cyc);
                end else begin
                    is_wr = (cur.idx == C_RPORT);
                    tmo = (cur.lat > TIMEOUT);
                    exp_rack = is_wr ? '0 : C_RPORT'(1 << cur.idx);
                    check("ack_rack", {62'd0, c_rack}, {62'd0, exp_rack});
                    check("ack_wack", {63'd0, c_wack}, {63'd0, is_wr});
                    check("ack_err", {63'd0, err}, {63'd0, tmo});
                    check("ack_busy", {63'd0, busy}, 64'd1);
                    check("ack_latency", 64'(cyc - issue_cyc), 64'((tmo ? TIMEOUT : cur.lat) + 1));
                    if (tmo) check("ack_err_port", {61'd0, err_port}, 64'(cur.idx));
                    if (!is_wr) model_dout[cur.idx] = tmo ? 64'd0 : cur.rdata;
                    for (int p = 0; p < C_RPORT; p++)
                        check("ack_dout_slice", c_dout[p*DATA_W +: DATA_W], model_dout[p]);
                    cur_valid = 1'b0;
                end
            end else if (err) begin
                checks++; errors++;
                $display("FAIL err_without_ack: got err=1 required 0 (cycle %0d)", cyc);
            end
        end
    end

    task automatic plan(input int idx, input int lat);
        acc_t a;
        a.idx = idx; a.addr = rq_addr[idx]; a.len = rq_len[idx]; a.wdata = rq_data[idx];
        a.lat = lat; a.rdata = rq_rdata[idx];
        exp_q.push_back(a);
        mem_q.push_back(a);
    endtask

    task automatic drive_req(input logic [2:0] mask);
        for (int p = 0; p < C_RPORT; p++) begin
            c_re[p] = mask[p];
            c_raddr[p*ADDR_W +: ADDR_W] = rq_addr[p];
            c_rlen[p*2 +: 2] = rq_len[p];
        end
        c_we = mask[2]; c_waddr = rq_addr[2]; c_wlen = rq_len[2]; c_din = rq_data[2];
    endtask

    task automatic randomize_reqs();
        for (int i = 0; i < NREQ; i++) begin
            rq_addr[i] = $urandom; rq_len[i] = 2'($urandom_range(0, 3));
            rq_data[i] = {$urandom, $urandom}; rq_rdata[i] = {$urandom, $urandom};
            rq_lat[i] = $urandom_range(1, 6);
        end
    endtask

    // All masked requesters assert together; each drops right after its own ack
    task automatic run_round(input logic [2:0] mask);
        int order[$];
        int c;
        int acks;
        int budget;
        for (int k = 1; k <= NREQ; k++) begin
            c = (rr_m + k) % NREQ;
            if (mask[c]) order.push_back(c);
        end
        foreach (order[i]) plan(order[i], rq_lat[order[i]]);
        rr_m = order[order.size() - 1];
        drive_req(mask);
        @(negedge clk);
        check("req_to_issue", {63'd0, m_re | m_we}, 64'd1);
        acks = 0; budget = 0;
        while (acks < order.size() && budget < 200) begin
            for (int p = 0; p < C_RPORT; p++)
                if (c_rack[p]) begin c_re[p] = 1'b0; acks++; end
            if (c_wack) begin c_we = 1'b0; acks++; end
            if (acks < order.size()) @(negedge clk);
            budget++;
        end
        if (acks < order.size()) begin
            checks++; errors++;
            $display("FAIL round_timeout: got %0d acks required %0d", acks, order.size());
        end
        c_re = '0; c_we = 1'b0;
        @(negedge clk);
        check("busy_after_round", {63'd0, busy}, 64'd0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // r0 and the writer hold their requests through 8 back-to-back accesses
    task automatic run_fairness();
        int c;
        int start;
        int acks;
        int budget;
        randomize_reqs();
        for (int j = 0; j < 8; j++) begin
            c = (rr_m + 1) % NREQ;
            if (c == 1) c = 2;
            plan(c, 1);
            rr_m = c;
        end
        drive_req(3'b101);
        start = cyc;
        acks = 0; budget = 0;
        while (acks < 8 && budget < 100) begin
            @(negedge clk);
            if (c_rack[0] || c_wack) acks++;
            budget++;
        end
        c_re = '0; c_we = 1'b0;
        check("fair_cycles", 64'(cyc - start), 64'd31);
        @(negedge clk);
        check("fair_busy_after", {63'd0, busy}, 64'd0);
    endtask

    task automatic run_reset_abort();
        randomize_reqs();
        plan(0, 3);
        drive_req(3'b001);
        @(negedge clk);
        check("rst_test_issue", {63'd0, m_re}, 64'd1);
        @(negedge clk);
        rst = 1'b1; c_re = '0; abort_cur = 1'b1; rr_m = C_RPORT;
        @(negedge clk);
        rst = 1'b0;
        check_zero("abort");
        repeat (2) @(negedge clk);
        check("abort_late_ack_dout", c_dout[63:0], 64'd0);
        check("abort_late_ack_flags", {61'd0, c_rack, busy}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; c_re = '0; c_raddr = '0; c_rlen = '0; c_we = 1'b0;
        c_waddr = '0; c_wlen = 2'b00; c_din = '0; rr_m = C_RPORT;
        repeat (3) @(negedge clk);
        check_zero("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("after_reset");

        randomize_reqs();
        for (int i = 0; i < NREQ; i++) rq_lat[i] = 1;
        run_round(3'b111);

        randomize_reqs();
        rq_addr[0] = 32'h0000_1000; rq_len[0] = 2'd3; rq_rdata[0] = 64'hDEAD_BEEF_0000_0001; rq_lat[0] = 2;
        run_round(3'b001);

        randomize_reqs();
        rq_addr[2] = 32'h0000_2008; rq_len[2] = 2'd0; rq_data[2] = 64'h55; rq_lat[2] = 2;
        run_round(3'b100);

        randomize_reqs();
        rq_lat[1] = 6;
        run_round(3'b010);

        randomize_reqs();
        rq_lat[2] = 4;
        run_round(3'b100);

        run_fairness();
        run_reset_abort();

        randomize_reqs();
        for (int i = 0; i < NREQ; i++) rq_lat[i] = 1;
        run_round(3'b111);

        for (int r = 0; r < 40; r++) begin
            randomize_reqs();
            run_round(3'($urandom_range(1, 7)));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Synchronous arbiter that shares one memory read/write port among C_RPORT read requesters (IF, MEM stages) and one write requester, using round-robin grant.
- Sits between the cache/pipeline request ports and the memory/UART-facing MMU port.
- Serialises accesses one at a time and returns per-port data and ack.
- Includes a per-access watchdog that terminates stuck memory transactions with an error flag.

Parameters:
- C_RPORT, 2, number of read requester ports (1..4)
- ADDR_W, 32, address width
- DATA_W, 64, data width
- TIMEOUT, 255, max wait cycles for memory ack; 0 disables the watchdog

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- c_re  in  C_RPORT  per-port read request, level
- c_raddr  in  C_RPORT*ADDR_W  packed read addresses; port t uses bits [(t+1)*ADDR_W-1 : t*ADDR_W]
- c_rlen  in  C_RPORT*2  packed 2-bit access length codes
- c_dout  out  C_RPORT*DATA_W  packed per-port read data
- c_rack  out  C_RPORT  per-port read ack, 1-cycle pulse
- c_we  in  1  write request, level
- c_waddr  in  ADDR_W  write address
- c_wlen  in  2  write length code
- c_din  in  DATA_W  write data
- c_wack  out  1  write ack, 1-cycle pulse
- m_re  out  1  memory read enable
- m_we  out  1  memory write enable
- m_raddr  out  ADDR_W  memory read address
- m_waddr  out  ADDR_W  memory write address
- m_rlen  out  2  memory read length
- m_wlen  out  2  memory write length
- m_dout  out  DATA_W  memory write data
- m_din  in  DATA_W  memory read data, valid when m_rack=1
- m_rack  in  1  memory read done, 1-cycle pulse
- m_wack  in  1  memory write done, 1-cycle pulse
- busy  out  1  high in any state other than IDLE
- err  out  1  1-cycle pulse on watchdog expiry
- err_port  out  3  requester index of the last timed-out access; C_RPORT denotes the write port

Behaviour:
- Reset: all outputs are 0, c_dout = 0, state = IDLE, rr_last = C_RPORT (write index), so read port 0 has first priority.
- Requester indices run 0..C_RPORT-1 for reads and C_RPORT for the write. Grant is round-robin starting from rr_last+1, modulo C_RPORT+1.
- IDLE:
  - Requests are sampled only in this state.
  - If any requester is pending, latch the winner's index, address, length and (for the write) data; update rr_last to the winner; go to ISSUE.
  - With no request pending, remain in IDLE.
- ISSUE (1 cycle):
  - Drive m_raddr/m_rlen and m_re=1 for a read, or m_waddr/m_wlen/m_dout and m_we=1 for a write.
  - Clear the watchdog counter; go to WAIT.
  - Total latency from the cycle a request is sampled in IDLE to m_re/m_we high is 1 cycle.
- WAIT:
  - Hold m_re/m_we and the address/data stable.
  - For a read, m_rack=1 means: capture m_din into that port's c_dout slice, drop m_re, go to RESP.
  - For a write, m_wack=1 means: drop m_we, go to RESP.
  - An ack of the wrong type (e.g. m_wack during a read) is ignored.
  - The watchdog counter increments each WAIT cycle. If TIMEOUT≠0 and the counter reaches TIMEOUT with no ack:
    - drop m_re/m_we;
    - for a read, write the port's c_dout slice to 0;
    - pulse err; set err_port = winner index;
    - go to RESP.
  - An ack arriving in the same cycle the counter reaches TIMEOUT counts as success, with no err.
- RESP (1 cycle):
  - Pulse c_rack[winner] or c_wack for exactly 1 cycle; go to IDLE.
  - A requester must drop its request in the cycle following its ack. A request still high when the arbiter returns to IDLE is treated as a new request.
- Minimum turnaround with an immediate memory ack is IDLE → ISSUE → WAIT → RESP → IDLE, i.e. 4 cycles per access.
- c_dout slices hold their value until that port's next completion; other ports' slices are unaffected.
- Memory acks seen outside WAIT (late acks, acks after reset) are ignored.
- Reset asserted mid-transaction aborts immediately to reset values. The abort issues no ack and no err.
- Request inputs that change while the arbiter is not in IDLE have no effect; the latched copy is used.

Test Plan:
- Single read: c_re[0]=1, c_raddr0=0x1000, c_rlen0=3; memory acks 2 cycles after m_re with m_din=0xDEADBEEF_00000001 → m_raddr=0x1000, m_rlen=3; c_rack[0] pulses 1 cycle; c_dout slice 0 = 0xDEADBEEF_00000001; slice 1 unchanged.
- Simultaneous requests after reset: c_re=2'b11 and c_we=1 asserted in the same cycle, each requester dropping its request after its ack → grant order r0, r1, w; each ack is 1 cycle; rr_last = 2 at the end.
- Fairness: r0 and w re-request continuously, memory acks immediately → grants alternate r0, w, r0, w; each access takes 4 cycles.
- Write path: c_we=1, c_waddr=0x2008, c_wlen=0, c_din=0x55 → m_we=1 with m_waddr=0x2008, m_dout=0x55; m_wack → c_wack pulse 1 cycle; m_re stays 0 throughout.
- Timeout: TIMEOUT=4, c_re[1]=1, memory never acks → m_re high for 4 WAIT cycles then drops; err pulses; err_port=1; c_rack[1] pulses; c_dout slice 1 = 0. A later stray m_rack is ignored.
- Reset mid-operation: rst in WAIT of a read → next cycle all outputs are 0 and busy=0, with no ack; a following m_rack is ignored. The next request is served from port 0 priority.
